// File: rtl/if_id_hazard_ctrl_if.sv
// Pipeline-side view of the IF/ID hazard controller: ID/EX hazard inputs and
// the PC / IF/ID / ID/EX sequencing controls it returns.
interface if_id_hazard_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic       branch_taken;
   logic       halt_req;
   logic       resume;
   logic       pc_write;
   logic       if_id_hold;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic       halted;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             branch_taken, halt_req, resume,
      input  pc_write, if_id_hold, if_id_flush, id_ex_bubble, halted
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             branch_taken, halt_req, resume,
      output pc_write, if_id_hold, if_id_flush, id_ex_bubble, halted
   );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID + PC sequencing FSM: load-use stall, ID branch flush, halt drain/resume.
// Optional saturating perf counters are enabled by `define IF_ID_HAZARD_CTRL_PERF_EN.
module if_id_hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int DRAIN_CYCLES      = 3
`ifdef IF_ID_HAZARD_CTRL_PERF_EN
   ,parameter int PERF_W           = 16
`endif
) (
   input  logic               clk,
   input  logic               reset,
   if_id_hazard_ctrl_if.slave bus
`ifdef IF_ID_HAZARD_CTRL_PERF_EN
   ,output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

   // The hazard cycle in RUN is the first stall cycle, so STALL loads LSC-2.
   localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);
   localparam logic [3:0] STALL_LOAD  = MULTI_STALL ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
   localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);

   state_t     state_r;
   state_t     next_state_s;
   logic [3:0] cnt_r;
   logic [3:0] next_cnt_s;
   logic       hazard_s;
   logic       pc_write_s;
   logic       hold_s;
   logic       flush_s;
   logic       bubble_s;
   logic       halted_s;

   assign hazard_s = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                     ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

   // State and down-counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= RUN;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= next_cnt_s;
      end
   end

   // Next-state and counter logic
   always_comb begin
      next_state_s = state_r;
      next_cnt_s   = cnt_r;
      case (state_r)
         RUN: begin
            if (bus.halt_req) begin
               next_state_s = DRAIN;
               next_cnt_s   = DRAIN_LOAD;
            end else if (hazard_s && MULTI_STALL) begin
               next_state_s = STALL;
               next_cnt_s   = STALL_LOAD;
            end else begin
               next_state_s = RUN;
               next_cnt_s   = 4'd0;
            end
         end
         STALL: begin
            if (cnt_r == 4'd0) begin
               next_state_s = RUN;
            end else begin
               next_cnt_s = cnt_r - 4'd1;
            end
         end
         DRAIN: begin
            if (cnt_r == 4'd0) begin
               next_state_s = HALTED;
            end else begin
               next_cnt_s = cnt_r - 4'd1;
            end
         end
         HALTED: begin
            if (bus.resume) begin
               next_state_s = RUN;
               next_cnt_s   = 4'd0;
            end else begin
               next_state_s = HALTED;
            end
         end
         default: begin
            next_state_s = RUN;
            next_cnt_s   = 4'd0;
         end
      endcase
   end

   // Output decode; reset overrides everything so IF/ID is flushed while held in reset
   always_comb begin
      pc_write_s = 1'b0;
      hold_s     = 1'b0;
      flush_s    = 1'b0;
      bubble_s   = 1'b0;
      halted_s   = 1'b0;
      if (reset) begin
         flush_s  = 1'b1;
         bubble_s = 1'b1;
      end else begin
         case (state_r)
            RUN: begin
               if (bus.halt_req) begin
                  hold_s = 1'b1;
               end else if (hazard_s) begin
                  hold_s   = 1'b1;
                  bubble_s = 1'b1;
               end else if (bus.branch_taken) begin
                  pc_write_s = 1'b1;
                  flush_s    = 1'b1;
               end else begin
                  pc_write_s = 1'b1;
               end
            end
            STALL: begin
               hold_s   = 1'b1;
               bubble_s = 1'b1;
            end
            DRAIN: begin
               flush_s  = 1'b1;
               bubble_s = 1'b1;
            end
            HALTED: begin
               flush_s  = 1'b1;
               bubble_s = 1'b1;
               halted_s = 1'b1;
            end
            default: begin
               flush_s  = 1'b1;
               bubble_s = 1'b1;
            end
         endcase
      end
   end

   assign bus.pc_write     = pc_write_s;
   assign bus.if_id_hold   = hold_s;
   assign bus.if_id_flush  = flush_s;
   assign bus.id_ex_bubble = bubble_s;
   assign bus.halted       = halted_s;

`ifdef IF_ID_HAZARD_CTRL_PERF_EN
   logic stall_inc_s;
   logic flush_inc_s;

   assign stall_inc_s = (state_r == STALL) | ((state_r == RUN) & ~bus.halt_req & hazard_s);
   assign flush_inc_s = (state_r == RUN) & ~bus.halt_req & ~hazard_s & bus.branch_taken;

   // Saturating performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= {PERF_W{1'b0}};
         flush_cnt <= {PERF_W{1'b0}};
      end else begin
         if (stall_inc_s && (stall_cnt != {PERF_W{1'b1}})) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
         end else begin
            stall_cnt <= stall_cnt;
         end
         if (flush_inc_s && (flush_cnt != {PERF_W{1'b1}})) begin
            flush_cnt <= flush_cnt + PERF_W'(1);
         end else begin
            flush_cnt <= flush_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Randomized bench for if_id_hazard_ctrl: two instances (1-cycle and 3-cycle load stall)
// share stimulus and are checked against a counter-based reference model.
module tb_if_id_hazard_ctrl;

   localparam int LSC_A = 1;
   localparam int DC_A  = 3;
   localparam int LSC_B = 3;
   localparam int DC_B  = 2;
   localparam int PW_A  = 16;
   localparam int PW_B  = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;

   // current stimulus, shared by both instances and the model
   logic [4:0] c_rs, c_rt, c_ert;
   logic       c_urt, c_mr, c_br, c_halt, c_res;

   // reference model state: remaining stall / drain cycles after the current one
   int lsc [2] = '{LSC_A, LSC_B};
   int dc  [2] = '{DC_A, DC_B};
   int stall_left [2];
   int drain_left [2];
   bit halted_m [2];
   int perf_stall [2];
   int perf_flush [2];
   int perf_max [2] = '{(1 << PW_A) - 1, (1 << PW_B) - 1};

   always #5 clk = ~clk;

   if_id_hazard_ctrl_if bus_a ();
   if_id_hazard_ctrl_if bus_b ();

`ifdef IF_ID_HAZARD_CTRL_PERF_EN
   logic [PW_A-1:0] stall_a, flush_a;
   logic [PW_B-1:0] stall_b, flush_b;
`endif

   if_id_hazard_ctrl #(
      .LOAD_STALL_CYCLES(LSC_A), .DRAIN_CYCLES(DC_A)
`ifdef IF_ID_HAZARD_CTRL_PERF_EN
      , .PERF_W(PW_A)
`endif
   ) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave)
`ifdef IF_ID_HAZARD_CTRL_PERF_EN
      , .stall_cnt(stall_a), .flush_cnt(flush_a)
`endif
   );

   if_id_hazard_ctrl #(
      .LOAD_STALL_CYCLES(LSC_B), .DRAIN_CYCLES(DC_B)
`ifdef IF_ID_HAZARD_CTRL_PERF_EN
      , .PERF_W(PW_B)
`endif
   ) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave)
`ifdef IF_ID_HAZARD_CTRL_PERF_EN
      , .stall_cnt(stall_b), .flush_cnt(flush_b)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit hazard_m();
      return c_mr && (c_ert != 5'd0) && ((c_ert == c_rs) || (c_urt && (c_ert == c_rt)));
   endfunction

   // {pc_write, hold, flush, bubble, halted} required this cycle
   function automatic logic [4:0] exp_out(input int k);
      if (reset)               return 5'b00110;
      if (halted_m[k])         return 5'b00111;
      if (drain_left[k] > 0)   return 5'b00110;
      if (stall_left[k] > 0)   return 5'b01010;
      if (c_halt)              return 5'b01000;
      if (hazard_m())          return 5'b01010;
      if (c_br)                return 5'b10100;
      return 5'b10000;
   endfunction

   task automatic clear_model(input int k);
      stall_left[k] = 0;
      drain_left[k] = 0;
      halted_m[k]   = 1'b0;
      perf_stall[k] = 0;
      perf_flush[k] = 0;
   endtask

   task automatic advance_model(input int k);
      if (reset) begin
         clear_model(k);
      end else if (halted_m[k]) begin
         if (c_res) halted_m[k] = 1'b0;
      end else if (drain_left[k] > 0) begin
         drain_left[k]--;
         if (drain_left[k] == 0) halted_m[k] = 1'b1;
      end else if (stall_left[k] > 0) begin
         stall_left[k]--;
         if (perf_stall[k] < perf_max[k]) perf_stall[k]++;
      end else if (c_halt) begin
         drain_left[k] = dc[k];
      end else if (hazard_m()) begin
         stall_left[k] = lsc[k] - 1;
         if (perf_stall[k] < perf_max[k]) perf_stall[k]++;
      end else if (c_br) begin
         if (perf_flush[k] < perf_max[k]) perf_flush[k]++;
      end
   endtask

   task automatic check_inst(input int k, input logic [4:0] obs);
      logic [4:0] e;
      string      n;
      e = exp_out(k);
      n = (k == 0) ? "a" : "b";
      check_val({n, ".pc_write"},     {31'd0, obs[4]}, {31'd0, e[4]});
      check_val({n, ".if_id_hold"},   {31'd0, obs[3]}, {31'd0, e[3]});
      check_val({n, ".if_id_flush"},  {31'd0, obs[2]}, {31'd0, e[2]});
      check_val({n, ".id_ex_bubble"}, {31'd0, obs[1]}, {31'd0, e[1]});
      check_val({n, ".halted"},       {31'd0, obs[0]}, {31'd0, e[0]});
   endtask

   // one cycle: drive at negedge, check mid-low-phase, advance model at posedge
   task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] ert,
                       input logic br, input logic hr, input logic res);
      @(negedge clk);
      reset = r; c_rs = rs; c_rt = rt; c_urt = urt; c_mr = mr; c_ert = ert;
      c_br = br; c_halt = hr; c_res = res;
      bus_a.id_rs = rs; bus_a.id_rt = rt; bus_a.id_uses_rt = urt; bus_a.ex_mem_read = mr;
      bus_a.ex_rt = ert; bus_a.branch_taken = br; bus_a.halt_req = hr; bus_a.resume = res;
      bus_b.id_rs = rs; bus_b.id_rt = rt; bus_b.id_uses_rt = urt; bus_b.ex_mem_read = mr;
      bus_b.ex_rt = ert; bus_b.branch_taken = br; bus_b.halt_req = hr; bus_b.resume = res;
      #1;
      if (r) begin
         clear_model(0);
         clear_model(1);
      end
      check_inst(0, {bus_a.pc_write, bus_a.if_id_hold, bus_a.if_id_flush, bus_a.id_ex_bubble, bus_a.halted});
      check_inst(1, {bus_b.pc_write, bus_b.if_id_hold, bus_b.if_id_flush, bus_b.id_ex_bubble, bus_b.halted});
`ifdef IF_ID_HAZARD_CTRL_PERF_EN
      check_val("a.stall_cnt", {16'd0, stall_a}, perf_stall[0]);
      check_val("a.flush_cnt", {16'd0, flush_a}, perf_flush[0]);
      check_val("b.stall_cnt", {30'd0, stall_b}, perf_stall[1]);
      check_val("b.flush_cnt", {30'd0, flush_b}, perf_flush[1]);
`endif
      @(posedge clk);
      advance_model(0);
      advance_model(1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      clear_model(0);
      clear_model(1);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      idle(2);
      // load-use on rs, single cycle
      step(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      idle(4);
      // hazard held together with a taken branch, then branch alone
      for (int i = 0; i < 3; i++) step(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      idle(2);
      // r0 never hazards; rt only counts when read
      step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      idle(3);
      // halt, drain, sit halted, resume
      step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      idle(3);
      // reset mid-drain
      step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      idle(1);
      step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      idle(6);
      // randomized traffic over a small register set to provoke hazards
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) == 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) == 0));
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
Pipeline sequencing controller for the IF/ID pipeline register and the PC.
- Detects load-use hazards and multi-cycle stalls.
- Handles taken branches resolved in ID.
- Handles halt drain and resume.
- Drives the hold, flush and bubble controls for IF/ID, PC and ID/EX from a registered FSM, so IF/ID never sees conflicting enable/flush/halt requests.

Parameters:
LOAD_STALL_CYCLES, 1, stall cycles inserted per load-use hazard (1..15)
DRAIN_CYCLES, 3, cycles to drain ID/EX/MEM/WB after halt before reporting halted (1..15)
PERF_W, 16, width of performance counters (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  5  destination register of load in EX
branch_taken  in  1  branch/jump in ID resolved taken this cycle
halt_req  in  1  halt opcode decoded in ID
resume  in  1  single-cycle pulse; leave HALTED
pc_write  out  1  1 = PC loads next value
if_id_hold  out  1  1 = IF/ID keeps current contents
if_id_flush  out  1  1 = IF/ID loads NOP 0xE0000000 at next edge
id_ex_bubble  out  1  1 = ID/EX loads control-zero bubble
halted  out  1  core halted, pipeline drained

Behaviour:
- States: RUN, STALL, DRAIN, HALTED. 4-bit down-counter cnt.
- Outputs are combinational from state plus current inputs. State and cnt are registered.
- Reset asserted: state=RUN, cnt=0. Outputs forced to pc_write=0, if_id_hold=0, if_id_flush=1, id_ex_bubble=1, halted=0. The first edge after deassertion behaves as RUN.
- hazard = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN, priority halt_req > hazard > branch_taken:
  - halt_req: pc_write=0, if_id_hold=1, id_ex_bubble=0 (halt proceeds down the pipe). Next state DRAIN, cnt=DRAIN_CYCLES-1.
  - hazard: pc_write=0, if_id_hold=1, id_ex_bubble=1. If LOAD_STALL_CYCLES==1, remain RUN. Else next state STALL, cnt=LOAD_STALL_CYCLES-2.
  - branch_taken: pc_write=1, if_id_flush=1, if_id_hold=0, id_ex_bubble=0. Exactly one cycle.
  - none: pc_write=1, all others 0.
- STALL: pc_write=0, if_id_hold=1, id_ex_bubble=1. branch_taken, halt_req and hazard are ignored. cnt decrements; at cnt==0 go to RUN. Inputs are re-evaluated in RUN, so the branch whose operand was the load resolves after the stall.
- DRAIN: pc_write=0, if_id_hold=0, if_id_flush=1, id_ex_bubble=1. All other inputs ignored. cnt decrements; at cnt==0 go to HALTED.
- HALTED: same outputs as DRAIN plus halted=1. resume=1 goes to RUN, with pc_write=1 from the following cycle. All other inputs are ignored.
- if_id_hold and if_id_flush are never both 1 (the reset override sets hold=0).
- pc_write=1 implies if_id_hold=0.
- Reset mid-STALL or mid-DRAIN aborts to RUN with no residual count.

Optional Feature:
Macro IF_ID_HAZARD_CTRL_PERF_EN.
- Defined, adds outputs:
  - stall_cnt [PERF_W]: cycles with id_ex_bubble=1 caused by hazard/STALL.
  - flush_cnt [PERF_W]: cycles with if_id_flush=1 from branch_taken.
- Counters are saturating, cleared by reset, and not incremented in DRAIN/HALTED.
- Not defined: ports and logic absent; all other behaviour identical.

Test Plan:
- Load-use, defaults: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> one cycle of pc_write=0, hold=1, bubble=1, then pc_write=1.
- LOAD_STALL_CYCLES=3, hazard held with branch_taken=1 -> 3 cycles stalled, branch ignored, then if_id_flush=1 for one cycle in RUN.
- ex_rt=0 with id_rs=0 and ex_mem_read=1 -> no stall. id_uses_rt=0 with ex_rt==id_rt -> no stall.
- halt_req=1 in RUN, DRAIN_CYCLES=3 -> halted=1 on the 4th cycle after halt_req cycle, pc_write=0 throughout. resume pulse -> halted=0, pc_write=1 the next cycle.
- Reset asserted asynchronously mid-DRAIN -> outputs take reset values immediately. After release: RUN, halted=0, no further drain.
- PERF_EN defined: 2 hazards plus 1 branch -> stall_cnt=2, flush_cnt=1. With PERF_W=2, 5 stalls -> stall_cnt saturates at 3.
